credit_fifo: RTL and testbench

Receiver-side buffer for a credit-flow-controlled link. The upstream sender spends one credit per push, and its `credit_counter` has `CREDITS_MAX` = `DEPTH`. This block stores pushed words in a FIFO and drains them through a valid/ready port. It drives `credit_ret` to the sender counter's `inc`: DEPTH initial credits after reset, then one credit per popped entry.

---
 rtl/credit_fifo.sv | 120 ++++++++++++
 tb/tb_credit_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_fifo.sv
// credit_fifo: receiver-side buffer for a credit-flow-controlled link.
// The sender spends one credit per push. This block stores pushed words
// and drains them through a valid/ready port. After reset it returns DEPTH
// initial credits, and then one credit for each popped entry, at most one
// credit per cycle.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   in_push    - sender writes in_data this cycle
//   in_data    - write data
//   out_valid  - head entry available (combinational from registered count)
//   out_ready  - consumer accepts head entry
//   out_data   - head entry (combinational read of storage)
//   credit_ret - one-cycle credit pulse to the sender counter's inc
//   count      - current occupancy, 0..DEPTH
//   overflow   - sticky flag, set by a push while full
module credit_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1),
  parameter int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_push,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 credit_ret,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic [CNT_WIDTH-1:0] pending, pending_nxt;
  logic                 credit_nxt;
  logic                 overflow_nxt;

  logic full;
  logic pop;
  logic push_ok;

  // Head of queue is visible straight from registered state.
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign full    = (count == FULL_CNT);
  assign pop     = out_valid & out_ready;
  assign push_ok = in_push & ~full;

  // Next-state computation for pointers, occupancy and credit return.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    pending_nxt  = pending;
    credit_nxt   = 1'b0;
    overflow_nxt = overflow;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    if (push_ok) begin
      wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_nxt = count + CNT_WIDTH'(1);
      2'b01:   count_nxt = count - CNT_WIDTH'(1);
      default: count_nxt = count;
    endcase

    // A push while full is dropped but latched as an error, even when a
    // pop frees a slot on the same edge.
    if (in_push && full) begin
      overflow_nxt = 1'b1;
    end

    // Pending credits drain one per cycle; pops queue behind the initial
    // credits. pending + sender credits + count == DEPTH, so no overflow.
    credit_nxt  = (pending != '0);
    pending_nxt = pending - CNT_WIDTH'(credit_nxt) + CNT_WIDTH'(pop);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= FULL_CNT;
      credit_ret <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      pending    <= pending_nxt;
      credit_ret <= credit_nxt;
      overflow   <= overflow_nxt;
    end
  end

  // Storage is not reset; a word is readable the cycle after its push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_credit_fifo.sv
// tb_credit_fifo: scoreboard bench for credit_fifo. Instance a uses
// DEPTH=8, instance b uses DEPTH=5. Stimulus pushes expected words into
// per-instance queues; monitors pop and compare whenever a word is accepted.
module tb_credit_fifo;

  localparam int unsigned DA = 8;
  localparam int unsigned DB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic       a_push = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_ready = 1'b0;
  logic       a_valid;
  logic [7:0] a_q;
  logic       a_cr;
  logic [3:0] a_count;
  logic       a_ovf;

  logic       b_push = 1'b0;
  logic [7:0] b_data = '0;
  logic       b_ready = 1'b0;
  logic       b_valid;
  logic [7:0] b_q;
  logic       b_cr;
  logic [2:0] b_count;
  logic       b_ovf;

  credit_fifo #(.DEPTH(DA), .WIDTH(8)) dut_a (
    .clk(clk), .rst(rst_n), .in_push(a_push), .in_data(a_data),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_q),
    .credit_ret(a_cr), .count(a_count), .overflow(a_ovf)
  );

  credit_fifo #(.DEPTH(DB), .WIDTH(8)) dut_b (
    .clk(clk), .rst(rst_n), .in_push(b_push), .in_data(b_data),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_q),
    .credit_ret(b_cr), .count(b_count), .overflow(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int cr_a = 0, pops_a = 0, cr_b = 0, pops_b = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d, input bit stored);
    a_push = 1'b1;
    a_data = d;
    if (stored) exp_a.push_back(d);
    tick();
    a_push = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    b_push = 1'b1;
    b_data = d;
    exp_b.push_back(d);
    tick();
    b_push = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    a_push = 1'b0; a_ready = 1'b0; b_push = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor for instance a.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a.delete();
      cr_a = 0;
      pops_a = 0;
    end else begin
      if (a_cr) cr_a++;
      check("a_valid_vs_count", int'(a_valid), (a_count != 0) ? 1 : 0);
      check("a_count_le_depth", (a_count <= DA) ? 1 : 0, 1);
      if (a_valid && a_ready) begin
        pops_a++;
        check("a_pop_expected", (exp_a.size() > 0) ? 1 : 0, 1);
        if (exp_a.size() > 0) check("a_data_order", int'(a_q), int'(exp_a.pop_front()));
      end
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_b.delete();
      cr_b = 0;
      pops_b = 0;
    end else begin
      if (b_cr) cr_b++;
      check("b_valid_vs_count", int'(b_valid), (b_count != 0) ? 1 : 0);
      check("b_count_le_depth", (b_count <= DB) ? 1 : 0, 1);
      if (b_valid && b_ready) begin
        pops_b++;
        check("b_pop_expected", (exp_b.size() > 0) ? 1 : 0, 1);
        if (exp_b.size() > 0) check("b_data_order", int'(b_q), int'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: reset and idle; initial credit burst on both instances.
    do_reset();
    check("t1_count", int'(a_count), 0);
    check("t1_valid", int'(a_valid), 0);
    check("t1_ovf", int'(a_ovf), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t1_a_credit", int'(a_cr), (k >= 1 && k <= 8) ? 1 : 0);
      check("t1_b_credit", int'(b_cr), (k >= 1 && k <= 5) ? 1 : 0);
    end

    // Test 2: three pushes, then drain; credit 1 cycle after each pop.
    tick();
    push_a(8'h11, 1'b1);
    push_a(8'h22, 1'b1);
    push_a(8'h33, 1'b1);
    check("t2_count3", int'(a_count), 3);
    check("t2_head", int'(a_q), 8'h11);
    a_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t2_credit", int'(a_cr), (k >= 2 && k <= 4) ? 1 : 0);
    end
    tick();
    a_ready = 1'b0;
    check("t2_count0", int'(a_count), 0);
    check("t2_queue_empty", exp_a.size(), 0);
    check("t2_credit_total", cr_a, int'(DA) + pops_a);

    // Test 3: DEPTH=5 instance, 12 push/pop pairs across pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) push_b(8'(8'h80 + r * 4 + i));
      check("t3_count4", int'(b_count), 4);
      b_ready = 1'b1;
      repeat (4) tick();
      b_ready = 1'b0;
      check("t3_count0", int'(b_count), 0);
    end
    repeat (3) tick();
    check("t3_queue_empty", exp_b.size(), 0);
    check("t3_pops", pops_b, 12);
    check("t3_ovf", int'(b_ovf), 0);
    check("t3_credit_total", cr_b, int'(DB) + pops_b);

    // Test 4: fill, push while full (dropped, sticky overflow, no credit).
    for (int i = 0; i < 8; i++) push_a(8'(8'h40 + i), 1'b1);
    check("t4_full_no_ovf", int'(a_ovf), 0);
    push_a(8'hAA, 1'b0);
    check("t4_count_full", int'(a_count), 8);
    check("t4_ovf_set", int'(a_ovf), 1);
    repeat (3) tick();
    check("t4_ovf_sticky", int'(a_ovf), 1);
    check("t4_no_extra_credit", cr_a, int'(DA) + pops_a);
    // Push while full with a concurrent pop: pop completes, push dropped.
    a_push = 1'b1;
    a_data = 8'hBB;
    a_ready = 1'b1;
    tick();
    a_push = 1'b0;
    check("t4_count_after_pop", int'(a_count), 7);
    repeat (10) tick();
    a_ready = 1'b0;
    check("t4_count0", int'(a_count), 0);
    check("t4_queue_empty", exp_a.size(), 0);
    check("t4_ovf_held", int'(a_ovf), 1);
    repeat (3) tick();
    check("t4_credit_total", cr_a, int'(DA) + pops_a);

    // Test 5: simultaneous push and pop at count=1 for 10 cycles.
    push_a(8'h50, 1'b1);
    check("t5_count1_start", int'(a_count), 1);
    a_push = 1'b1;
    a_data = 8'h51;
    exp_a.push_back(8'h51);
    a_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_count1", int'(a_count), 1);
      check("t5_credit", int'(a_cr), (i >= 1) ? 1 : 0);
      if (i < 9) begin
        a_data = 8'(8'h52 + i);
        exp_a.push_back(a_data);
      end else begin
        a_push = 1'b0;
      end
    end
    tick();
    a_ready = 1'b0;
    check("t5_count0", int'(a_count), 0);
    repeat (3) tick();
    check("t5_queue_empty", exp_a.size(), 0);
    check("t5_credit_total", cr_a, int'(DA) + pops_a);

    // Test 6: reset clears sticky overflow asynchronously.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ovf", int'(a_ovf), 0);
    check("t6_rst_count", int'(a_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_push = 1'b1;
    a_data = 8'h61;
    exp_a.push_back(8'h61);
    // Two pushes and two pops inside the initial-credit phase.
    fork
      begin
        tick();
        a_data = 8'h62;
        exp_a.push_back(8'h62);
        tick();
        a_push = 1'b0;
        a_ready = 1'b1;
        tick();
        tick();
        a_ready = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          check("t6_credit_10", int'(a_cr), (k >= 1 && k <= 10) ? 1 : 0);
        end
      end
    join
    check("t6_pops", pops_a, 2);
    check("t6_credit_total", cr_a, int'(DA) + pops_a);

    // Reset asserted in the middle of an initial-credit burst.
    do_reset();
    a_push = 1'b1;
    a_data = 8'h71;
    exp_a.push_back(8'h71);
    tick();
    a_push = 1'b0;
    tick();
    tick();
    #2;
    check("t6_pre_credit", int'(a_cr), 1);
    check("t6_pre_count", int'(a_count), 1);
    rst_n = 1'b0;
    #1;
    check("t6_mid_credit", int'(a_cr), 0);
    check("t6_mid_count", int'(a_count), 0);
    check("t6_mid_valid", int'(a_valid), 0);
    check("t6_mid_ovf", int'(a_ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check("t6_restart_credit", int'(a_cr), (k >= 1 && k <= 8) ? 1 : 0);
    end
    check("t6_restart_total", cr_a, int'(DA));
    check("t6_restart_count", int'(a_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
